mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit. Sits between the EX/MEM register and mem_wb.
//  Passes ALU results straight through to mem_wb.
//  Runs multi-cycle LB/LBU/LH/LHU/LW/SB/SH/SW accesses over a req/ack data-memory port.
//  Stalls the pipeline through stallreq until each access completes.
// PARAMETERS
//  ACK_TIMEOUT  16  max cycles in WAIT before abort with bus_err; 0 = no timeout
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset, asynchronous, active-high
//  ex_wd        in   5   dest reg addr from EX/MEM
//  ex_wreg      in   1   reg write enable from EX/MEM
//  ex_wdata     in   32  ALU result
//  ex_whilo     in   1   HI/LO write enable
//  ex_hi        in   32  HI value
//  ex_lo        in   32  LO value
//  ex_memop     in   4   0=none 1=LB 2=LBU 3=LH 4=LHU 5=LW 8=SB 9=SH 10=SW; others=none
//  ex_maddr     in   32  effective address
//  ex_sdata     in   32  store data (rt)
//  stall_in     in   1   downstream hold; MEM stage must not advance
//  mem_wd       out  5   to mem_wb
//  mem_wreg     out  1   to mem_wb
//  mem_wdata    out  32  to mem_wb
//  mem_whilo    out  1   to mem_wb
//  mem_hi       out  32  to mem_wb
//  mem_lo       out  32  to mem_wb
//  stallreq     out  1   request pipeline stall
//  addr_err     out  1   1-cycle pulse: misaligned access suppressed
//  bus_err      out  1   1-cycle pulse: access aborted on timeout
//  dmem_req     out  1   access request, held until ack
//  dmem_we      out  1   1=store
//  dmem_addr    out  32  word address {ex_maddr[31:2],2'b00}
//  dmem_sel     out  4   byte enables, bit3 = bits[31:24]
//  dmem_wdata   out  32  byte/half replicated store data
//  dmem_ack     in   1   access complete; rdata valid same cycle
//  dmem_rdata   in   32  read word
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0, load buffer 0.
//    Outputs at reset: dmem_req/dmem_we/stallreq/addr_err/bus_err = 0; dmem_sel/dmem_addr/dmem_wdata = 0.
//  - Big-endian: offset 0 maps to bits[31:24]. Byte sel = 4'b1000 >> a[1:0]. Half sel = a[1] ? 0011 : 1100. Word sel = 1111.
//  - Misaligned: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0.
//    No dmem access; mem_wreg = 0; addr_err = 1 for one cycle; stallreq = 0.
//  - Non-memory op in IDLE: mem_* = ex_* combinationally; stallreq = 0; zero added latency.
//  - FSM IDLE->WAIT: taken on an aligned mem op in IDLE.
//    stallreq = 1 combinationally in that cycle; dmem_req/addr/sel/we/wdata are registered, driven from the next cycle.
//  - WAIT: dmem_req = 1; request fields held stable; stallreq = 1; counter increments each cycle.
//    WAIT->DONE on dmem_ack. Loads capture dmem_rdata (extracted, then zero- or sign-extended) into a buffer.
//    dmem_req drops in the cycle after ack.
//    WAIT->DONE on counter == ACK_TIMEOUT-1 without ack: bus_err pulses 1; load result forced 0 and mem_wreg = 0.
//  - DONE: stallreq = 0.
//    mem_wdata = load buffer for loads, ex_wdata for stores. mem_wreg = ex_wreg, or 0 on bus_err.
//    Other mem_* pass through.
//    DONE->IDLE when stall_in = 0; DONE holds while stall_in = 1.
//  - ack in the same cycle as the timeout limit: ack wins, no bus_err.
//  - ack outside WAIT is ignored.
//  - rst mid-access: immediate return to IDLE; dmem_req drops asynchronously; captured data discarded.
// TESTING
//  1. ALU op, ex_wdata=32'h1234 -> mem_wdata=32'h1234 same cycle; stallreq=0; dmem_req never set.
//  2. LB a=..01, rdata=32'h11F0_2233, ack after 3 cycles -> sel=0100; stallreq held 4 cycles; mem_wdata=32'hFFFF_FFF0.
//     Same stimulus as LBU -> mem_wdata=32'h0000_00F0.
//  3. SH a=..02, sdata=32'h0000_ABCD -> dmem_we=1; sel=0011; wdata=32'hABCD_ABCD; mem_wreg=0.
//  4. LW a=..02 -> addr_err pulse; no dmem_req; mem_wreg=0; stallreq=0.
//  5. LW with no ack, ACK_TIMEOUT=16 -> bus_err after 16 WAIT cycles; mem_wreg=0.
//     Ack on cycle 16 -> normal completion, no bus_err.
//  6. rst asserted in WAIT -> dmem_req=0 immediately; state IDLE.
//     stall_in=1 in DONE -> outputs held until stall_in=0.

Source files
------------

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: ALU results pass through; LB..SW run over a req/ack data port.
// Latency: none for non-memory ops; memory ops take 1 launch + N wait cycles + 1 done cycle.
// Backpressure: stallreq holds the pipeline until the access completes; DONE holds while stall_in is set.
module mem_lsu #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_maddr,
    input  logic [31:0] ex_sdata,
    input  logic        stall_in,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        stallreq,
    output logic        addr_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_sel,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

    typedef struct packed {
        logic        ld;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [3:0]  op;
        logic [1:0]  off;
    } acc_t;

    logic [1:0]    state;
    acc_t          acc_q;
    acc_t          acc_d;
    logic [CW-1:0] cnt;
    logic [31:0]   ld_buf;
    logic          err_q;
    logic          bus_err_q;

    logic is_load;
    logic is_store;
    logic misalign;
    logic launch;
    logic timeout;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        case (ex_memop)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load  = 1'b1;
                misalign = ex_maddr[0];
            end
            OP_LW: begin
                is_load  = 1'b1;
                misalign = |ex_maddr[1:0];
            end
            OP_SB: is_store = 1'b1;
            OP_SH: begin
                is_store = 1'b1;
                misalign = ex_maddr[0];
            end
            OP_SW: begin
                is_store = 1'b1;
                misalign = |ex_maddr[1:0];
            end
            default: ;
        endcase
    end

    assign launch  = (state == ST_IDLE) && (is_load || is_store) && !misalign;
    assign timeout = (ACK_TIMEOUT != 0) && (cnt == CNT_LAST);

    // Request fields are captured at launch so the bus sees them stable for the whole wait.
    always_comb begin
        acc_d       = '0;
        acc_d.ld    = is_load;
        acc_d.we    = is_store;
        acc_d.addr  = {ex_maddr[31:2], 2'b00};
        acc_d.op    = ex_memop;
        acc_d.off   = ex_maddr[1:0];
        case (ex_memop)
            OP_LB, OP_LBU, OP_SB: acc_d.sel = 4'b1000 >> ex_maddr[1:0];
            OP_LH, OP_LHU, OP_SH: acc_d.sel = ex_maddr[1] ? 4'b0011 : 4'b1100;
            default:              acc_d.sel = 4'b1111;
        endcase
        case (ex_memop)
            OP_SB:   acc_d.wdata = {4{ex_sdata[7:0]}};
            OP_SH:   acc_d.wdata = {2{ex_sdata[15:0]}};
            OP_SW:   acc_d.wdata = ex_sdata;
            default: acc_d.wdata = '0;
        endcase
    end

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] off,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op)
            OP_LB:   load_extend = {{24{b[7]}}, b};
            OP_LBU:  load_extend = {24'd0, b};
            OP_LH:   load_extend = {{16{h[15]}}, h};
            OP_LHU:  load_extend = {16'd0, h};
            OP_LW:   load_extend = w;
            default: load_extend = '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc_q     <= '0;
            cnt       <= '0;
            ld_buf    <= '0;
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        state <= ST_WAIT;
                        acc_q <= acc_d;
                        cnt   <= '0;
                        err_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // An ack coinciding with the timeout limit still completes normally.
                    if (dmem_ack) begin
                        state  <= ST_DONE;
                        ld_buf <= acc_q.ld ? load_extend(acc_q.op, acc_q.off, dmem_rdata) : 32'd0;
                    end else if (timeout) begin
                        state     <= ST_DONE;
                        ld_buf    <= '0;
                        err_q     <= 1'b1;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!stall_in) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stallreq   = launch || (state == ST_WAIT);
    assign addr_err   = (state == ST_IDLE) && (is_load || is_store) && misalign;
    assign bus_err    = bus_err_q;
    assign dmem_req   = (state == ST_WAIT);
    assign dmem_we    = acc_q.we;
    assign dmem_addr  = acc_q.addr;
    assign dmem_sel   = acc_q.sel;
    assign dmem_wdata = acc_q.wdata;

    // While stalled the stage presents a bubble so mem_wb never commits a half-done access.
    always_comb begin
        mem_wd    = ex_wd;
        mem_hi    = ex_hi;
        mem_lo    = ex_lo;
        mem_whilo = ex_whilo;
        mem_wdata = ex_wdata;
        mem_wreg  = ex_wreg;
        if (addr_err) begin
            mem_wreg = 1'b0;
        end
        if (stallreq) begin
            mem_wreg  = 1'b0;
            mem_whilo = 1'b0;
        end
        if (state == ST_DONE) begin
            mem_wdata = acc_q.ld ? ld_buf : ex_wdata;
            mem_wreg  = ex_wreg && !err_q;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a per-transaction model predicts every cycle's outputs,
// and literal expectations pin the model on the key cases.
module tb_mem_lsu;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr;
    logic [31:0] ex_sdata;
    logic        stall_in;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        stallreq;
    logic        addr_err;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    mem_lsu #(.ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_memop(ex_memop), .ex_maddr(ex_maddr),
        .ex_sdata(ex_sdata), .stall_in(stall_in),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .stallreq(stallreq), .addr_err(addr_err),
        .bus_err(bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_sel(dmem_sel), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Expected-output frame for the current cycle, written by the driver.
    logic        exp_on = 1'b0;
    logic        e_stall, e_req, e_we, e_chk_wd, e_aerr, e_berr, e_chk_mem, e_mwreg;
    logic [31:0] e_addr, e_wd, e_mwdata;
    logic [3:0]  e_sel;

    // Observations gathered per transaction for the literal checks.
    int          obs_stall;
    logic        obs_req_seen, obs_aerr, obs_berr, obs_we;
    logic [3:0]  obs_sel;
    logic [31:0] obs_dwdata, obs_mwdata;
    logic        obs_mwreg;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on && !rst) begin
            check("stallreq", {31'd0, stallreq}, {31'd0, e_stall});
            check("dmem_req", {31'd0, dmem_req}, {31'd0, e_req});
            check("addr_err", {31'd0, addr_err}, {31'd0, e_aerr});
            check("bus_err",  {31'd0, bus_err},  {31'd0, e_berr});
            if (e_req) begin
                check("dmem_we",   {31'd0, dmem_we}, {31'd0, e_we});
                check("dmem_addr", dmem_addr, e_addr);
                check("dmem_sel",  {28'd0, dmem_sel}, {28'd0, e_sel});
                if (e_chk_wd) check("dmem_wdata", dmem_wdata, e_wd);
            end
            if (e_chk_mem) begin
                check("mem_wdata", mem_wdata, e_mwdata);
                check("mem_wreg",  {31'd0, mem_wreg}, {31'd0, e_mwreg});
                check("mem_wd",    {27'd0, mem_wd}, {27'd0, ex_wd});
                check("mem_whilo", {31'd0, mem_whilo}, {31'd0, ex_whilo});
                check("mem_hi",    mem_hi, ex_hi);
                check("mem_lo",    mem_lo, ex_lo);
                obs_mwdata = mem_wdata;
                obs_mwreg  = mem_wreg;
            end
            if (stallreq) obs_stall++;
            if (dmem_req) begin
                obs_req_seen = 1'b1;
                obs_we       = dmem_we;
                obs_sel      = dmem_sel;
                obs_dwdata   = dmem_wdata;
            end
            if (addr_err) obs_aerr = 1'b1;
            if (bus_err)  obs_berr = 1'b1;
        end
    end

    // Big-endian load result from the architectural rules, using shifts rather than selects.
    function automatic logic [31:0] model_load(input logic [3:0] op, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (3 - int'(off)))) & 32'hFF;
        h = (w >> (off[1] ? 0 : 16)) & 32'hFFFF;
        case (op)
            4'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            4'd2:    return b;
            4'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            4'd4:    return h;
            4'd5:    return w;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: ack_at = WAIT cycle carrying ack (0 = never); hold = DONE cycles with stall_in.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sdata,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int ack_at,
                          input int hold, input logic ack_stray);
        logic ld, st, mis, tmo;
        logic [1:0] off;
        logic [3:0] sel;
        logic [31:0] swd;
        int nwait;
        off = a[1:0];
        ld  = (op >= 4'd1 && op <= 4'd5);
        st  = (op >= 4'd8 && op <= 4'd10);
        mis = ((op == 4'd3 || op == 4'd4 || op == 4'd9) && off[0]) ||
              ((op == 4'd5 || op == 4'd10) && off != 2'd0);
        if (op == 4'd1 || op == 4'd2 || op == 4'd8)      sel = 4'b1000 >> off;
        else if (op == 4'd3 || op == 4'd4 || op == 4'd9) sel = off[1] ? 4'b0011 : 4'b1100;
        else                                             sel = 4'b1111;
        if (op == 4'd8)      swd = {4{sdata[7:0]}};
        else if (op == 4'd9) swd = {2{sdata[15:0]}};
        else                 swd = sdata;

        ex_memop = op; ex_maddr = a; ex_sdata = sdata; ex_wdata = wdata;
        ex_wreg = !st; ex_wd = 5'($urandom); ex_whilo = 1'($urandom);
        ex_hi = $urandom; ex_lo = $urandom;
        stall_in = 1'b0; dmem_ack = ack_stray; dmem_rdata = 32'hDEAD_BEEF;
        obs_stall = 0; obs_req_seen = 0; obs_aerr = 0; obs_berr = 0; obs_we = 0;
        obs_sel = 0; obs_dwdata = 0; obs_mwdata = 0; obs_mwreg = 0;
        e_req = 0; e_we = 0; e_chk_wd = 0; e_addr = 0; e_sel = 0; e_wd = 0;
        e_aerr = 0; e_berr = 0;
        exp_on = 1'b1;

        if (!(ld || st) || mis) begin
            e_stall = 0; e_aerr = mis; e_chk_mem = 1;
            e_mwdata = wdata; e_mwreg = ex_wreg && !mis;
            tick();
            return;
        end

        tmo   = (ack_at == 0 || ack_at > TMO);
        nwait = tmo ? TMO : ack_at;
        e_stall = 1; e_chk_mem = 0;
        tick();
        for (int k = 1; k <= nwait; k++) begin
            dmem_ack   = !tmo && (k == nwait);
            dmem_rdata = dmem_ack ? rdata : 32'hDEAD_BEEF;
            e_req = 1; e_we = st; e_addr = {a[31:2], 2'b00}; e_sel = sel;
            e_wd = swd; e_chk_wd = st;
            tick();
        end
        dmem_ack = ack_stray; dmem_rdata = 32'hDEAD_BEEF;
        e_stall = 0; e_req = 0; e_chk_mem = 1;
        e_mwdata = ld ? (tmo ? 32'd0 : model_load(op, off, rdata)) : wdata;
        e_mwreg  = ex_wreg && !tmo;
        for (int h = 0; h <= hold; h++) begin
            stall_in = (h < hold);
            e_berr   = tmo && (h == 0);
            tick();
        end
        stall_in = 1'b0; dmem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_wd = 0; ex_wreg = 0; ex_wdata = 0; ex_whilo = 0; ex_hi = 0; ex_lo = 0;
        ex_memop = 0; ex_maddr = 0; ex_sdata = 0; stall_in = 0; dmem_ack = 0; dmem_rdata = 0;
        e_stall = 0; e_req = 0; e_we = 0; e_chk_wd = 0; e_aerr = 0; e_berr = 0;
        e_chk_mem = 0; e_mwreg = 0; e_addr = 0; e_wd = 0; e_mwdata = 0; e_sel = 0;
        #3;
        check("rst_outputs", {stallreq, dmem_req, dmem_we, addr_err, bus_err, dmem_sel},
              32'd0);
        check("rst_dmem_addr", dmem_addr, 32'd0);
        check("rst_dmem_wdata", dmem_wdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        run_op(4'd0, 32'h0, 32'h0, 32'h0000_1234, 32'h0, 0, 0, 1'b1);
        check("alu_wdata", obs_mwdata, 32'h0000_1234);
        check("alu_no_req", {31'd0, obs_req_seen}, 32'd0);

        run_op(4'd1, 32'h0000_1001, 32'h0, 32'h5, 32'h11F0_2233, 3, 0, 1'b0);
        check("lb_stall_cycles", obs_stall, 32'd4);
        check("lb_sel", {28'd0, obs_sel}, 32'h4);
        check("lb_wdata", obs_mwdata, 32'hFFFF_FFF0);
        run_op(4'd2, 32'h0000_1001, 32'h0, 32'h5, 32'h11F0_2233, 3, 0, 1'b0);
        check("lbu_wdata", obs_mwdata, 32'h0000_00F0);
        run_op(4'd3, 32'h0000_1002, 32'h0, 32'h6, 32'h11F0_8233, 2, 0, 1'b0);
        check("lh_wdata", obs_mwdata, 32'hFFFF_8233);
        run_op(4'd4, 32'h0000_1000, 32'h0, 32'h6, 32'h91F0_8233, 1, 0, 1'b0);
        check("lhu_wdata", obs_mwdata, 32'h0000_91F0);
        run_op(4'd2, 32'h0000_1003, 32'h0, 32'h6, 32'h0102_03A4, 2, 0, 1'b0);

        run_op(4'd9, 32'h0000_2002, 32'h0000_ABCD, 32'h77, 32'h0, 2, 0, 1'b0);
        check("sh_we", {31'd0, obs_we}, 32'd1);
        check("sh_sel", {28'd0, obs_sel}, 32'h3);
        check("sh_dwdata", obs_dwdata, 32'hABCD_ABCD);
        check("sh_wreg", {31'd0, obs_mwreg}, 32'd0);
        run_op(4'd8, 32'h0000_2003, 32'h1234_565A, 32'h78, 32'h0, 1, 0, 1'b0);
        check("sb_dwdata", obs_dwdata, 32'h5A5A_5A5A);
        run_op(4'd10, 32'h0000_2004, 32'hCAFE_F00D, 32'h79, 32'h0, 4, 0, 1'b0);

        run_op(4'd5, 32'h0000_3002, 32'h0, 32'h9, 32'h0, 1, 0, 1'b0);
        check("lw_mis_aerr", {31'd0, obs_aerr}, 32'd1);
        check("lw_mis_noreq", {31'd0, obs_req_seen}, 32'd0);
        check("lw_mis_wreg", {31'd0, obs_mwreg}, 32'd0);
        run_op(4'd3, 32'h0000_3001, 32'h0, 32'h9, 32'h0, 1, 0, 1'b0);
        run_op(4'd10, 32'h0000_3003, 32'h0, 32'h9, 32'h0, 1, 0, 1'b0);
        run_op(4'd0, 32'h0000_3003, 32'h0, 32'hA5A5_0000, 32'h0, 0, 0, 1'b0);

        run_op(4'd5, 32'h0000_4000, 32'h0, 32'hB, 32'h1111_2222, 0, 0, 1'b0);
        check("tmo_berr", {31'd0, obs_berr}, 32'd1);
        check("tmo_stall_cycles", obs_stall, 32'd17);
        check("tmo_wreg", {31'd0, obs_mwreg}, 32'd0);
        run_op(4'd5, 32'h0000_4000, 32'h0, 32'hB, 32'h1111_2222, 16, 0, 1'b0);
        check("ack16_berr", {31'd0, obs_berr}, 32'd0);
        check("ack16_wdata", obs_mwdata, 32'h1111_2222);

        run_op(4'd5, 32'h0000_5008, 32'h0, 32'hC, 32'h8765_4321, 2, 3, 1'b1);
        check("hold_wdata", obs_mwdata, 32'h8765_4321);
        run_op(4'd0, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 0, 0, 1'b0);

        // Reset in the middle of a wait.
        exp_on = 1'b0;
        ex_memop = 4'd5; ex_maddr = 32'h0000_6000; ex_wreg = 1'b1; dmem_ack = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        ex_memop = 4'd0; ex_wdata = 32'h0000_0042;
        #1;
        check("rst_mid_idle", {31'd0, stallreq}, 32'd0);
        check("rst_mid_wdata", mem_wdata, 32'h0000_0042);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(4'd1, 32'h0000_6002, 32'h0, 32'h1, 32'h0000_7F00, 2, 0, 1'b0);
        check("post_rst_lb", obs_mwdata, 32'h0000_007F);
        run_op(4'd0, 32'h0, 32'h0, 32'h0000_0055, 32'h0, 0, 0, 1'b0);
        exp_on = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
